serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 13 +
 rtl/full_adder.sv | 31 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder made of two half adders; the carry-out is the OR of
// the two half-adder carries, which can never both be high.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic ab_sum;
    logic ab_carry;
    logic abc_carry;

    half_adder u_ha_ab (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (ab_sum),
        .carry_o (ab_carry)
    );

    half_adder u_ha_cin (
        .a_i     (ab_sum),
        .b_i     (cin_i),
        .sum_o   (sum_o),
        .carry_o (abc_carry)
    );

    assign cout_o = ab_carry | abc_carry;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder, the basic building block of the serial adder slice.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through a single
// full-adder slice, one bit per clock, and presents the registered result.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c,
    output state_e           o_state
);

    // Handshake: i_start is sampled only in IDLE, where it is always accepted
    // and i_a/i_b are captured; o_done is a one-cycle pulse, and o_sum/o_c
    // stay stable from that pulse until the next accepted start.

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_q, c_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_next;

    full_adder u_full_adder (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // The new sum bit enters at the MSB; the LSB drops out of the W-1 bit
    // shift register, so after WIDTH steps res_next is the complete sum.
    assign res_next = {fa_sum, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_d     = c_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_next[WIDTH-1:1];
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = res_next;
                    c_d     = fa_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
        end
    end

    assign o_busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign o_done  = (state_q == ST_DONE);
    assign o_sum   = sum_q;
    assign o_c     = c_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: table of hand-computed
// sums run back-to-back, plus ignored-start and mid-run reset sequences.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_sum;
    logic         o_c;
    state_e       o_state;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_c     (o_c),
        .o_state (o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         c;
    } vec_t;

    int           checks   = 0;
    int           failures = 0;
    logic [W:0]   exp_q[$];
    logic [W-1:0] held_sum;
    logic         held_c;
    vec_t         vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the IDLE negedge after DONE so the
    // next call starts exactly back-to-back.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] esum, input logic ec, input string tag);
        int         lat;
        int         busy_cnt;
        bit         stable;
        logic [W:0] exp;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        exp_q.push_back({ec, esum});
        @(posedge i_clk);
        @(negedge i_clk);
        i_start  = 1'b0;
        i_a      = ~a;
        i_b      = ~b;
        lat      = 0;
        busy_cnt = 0;
        stable   = 1'b1;
        while (!o_done && lat < 40) begin
            if (o_busy) busy_cnt++;
            if (o_sum !== held_sum || o_c !== held_c) stable = 1'b0;
            @(negedge i_clk);
            lat++;
        end
        exp = exp_q.pop_front();
        if (!o_done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=no_done exp=done_within_40", tag);
            return;
        end
        if (o_busy) busy_cnt++;
        check({tag, "_sum"}, 32'(o_sum), 32'(exp[W-1:0]));
        check({tag, "_c"}, 32'(o_c), 32'(exp[W]));
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
        check({tag, "_stable_in_run"}, 32'(stable), 32'd1);
        held_sum = exp[W-1:0];
        held_c   = exp[W];
        @(negedge i_clk);
        check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_held_sum"}, 32'({o_c, o_sum}), 32'({held_c, held_sum}));
    endtask

    initial begin
        int           done_cnt;
        int           busy_seen;
        logic [W-1:0] got_sum;
        logic         got_c;

        vecs[0] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, c: 1'b1};
        vecs[1] = '{a: 8'h10, b: 8'h20, sum: 8'h30, c: 1'b0};
        vecs[2] = '{a: 8'hF0, b: 8'h20, sum: 8'h10, c: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, c: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, c: 1'b0};
        vecs[5] = '{a: 8'hA5, b: 8'h5A, sum: 8'hFF, c: 1'b0};
        vecs[6] = '{a: 8'h80, b: 8'h80, sum: 8'h00, c: 1'b1};
        vecs[7] = '{a: 8'h01, b: 8'h01, sum: 8'h02, c: 1'b0};

        i_rst_n  = 1'b0;
        i_start  = 1'b0;
        i_a      = '0;
        i_b      = '0;
        held_sum = '0;
        held_c   = 1'b0;

        repeat (2) @(negedge i_clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_sum", 32'(o_sum), 32'd0);
        check("rst_c", 32'(o_c), 32'd0);
        check("rst_state", 32'(o_state), 32'(ST_IDLE));

        // Start raised together with reset release: the first edge accepts it.
        i_rst_n = 1'b1;
        run_op(8'h00, 8'h00, 8'h00, 1'b0, "zero");

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].c, $sformatf("vec%0d", i));

        // Start pulse with new operands during RUN must be ignored.
        i_a     = 8'h5A;
        i_b     = 8'h3C;
        i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (2) @(negedge i_clk);
        i_a     = 8'h01;
        i_b     = 8'h01;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        done_cnt = 0;
        got_sum  = '0;
        got_c    = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (o_done) begin
                done_cnt++;
                got_sum = o_sum;
                got_c   = o_c;
            end
            @(negedge i_clk);
        end
        check("ign_done_count", 32'(done_cnt), 32'd1);
        check("ign_sum", 32'(got_sum), 32'h96);
        check("ign_c", 32'(got_c), 32'd0);
        check("ign_no_queue", 32'(o_busy), 32'd0);

        // Reset in the fourth RUN cycle aborts with no done pulse.
        i_a     = 8'hAA;
        i_b     = 8'h55;
        i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_sum", 32'(o_sum), 32'd0);
        check("abort_c", 32'(o_c), 32'd0);
        check("abort_state", 32'(o_state), 32'(ST_IDLE));
        held_sum = '0;
        held_c   = 1'b0;
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        done_cnt  = 0;
        busy_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (o_done) done_cnt++;
            if (o_busy) busy_seen++;
            @(negedge i_clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_wait_idle", 32'(busy_seen), 32'd0);
        run_op(8'h80, 8'h80, 8'h00, 1'b1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
